// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
// Issues req/gnt/rvalid data-memory transactions, steers store lanes,
// extends load data, flags misaligned accesses and response timeouts,
// and holds the MEM/WB pipeline register. Upstream stages are frozen
// through stall_o while an access is outstanding, so the EXE/MEM inputs
// stay stable for the whole transaction.
module mem_stage #(
  parameter int DATA_WIDTH   = 32,
  parameter int RESP_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic                  mem_to_reg_i,
  input  logic                  reg_write_i,
  input  logic [4:0]            rd_addr_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  output logic                  dm_req_o,
  output logic [3:0]            dm_we_o,
  output logic [DATA_WIDTH-1:0] dm_addr_o,
  output logic [DATA_WIDTH-1:0] dm_wdata_o,
  input  logic                  dm_gnt_i,
  input  logic                  dm_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dm_rdata_i,
  output logic                  stall_o,
  output logic [DATA_WIDTH-1:0] fwd_data_o,
  output logic                  misaligned_o,
  output logic                  bus_err_o,
  output logic                  wb_valid_o,
  output logic                  wb_reg_write_o,
  output logic [4:0]            wb_rd_o,
  output logic [DATA_WIDTH-1:0] wb_data_o
);

  localparam int CNT_W = $clog2(RESP_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               access;
  logic               misaligned_c;
  logic               go;
  logic               is_store;
  logic               req_c;
  logic               stall_c;
  logic               timeout_c;
  logic               err_c;
  logic [1:0]         addr_lo;
  logic [31:0]        load_ext;

  logic               wb_valid_p1;
  logic               wb_reg_write_p1;
  logic [4:0]         wb_rd_p1;
  logic [31:0]        wb_data_p1;
  logic               misaligned_p1;
  logic               bus_err_p1;

  // Byte enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] steer_we(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   steer_we = 4'b0001 << a;
      2'b01:   steer_we = 4'b0011 << a;
      default: steer_we = 4'b1111;
    endcase
  endfunction

  // Replicate the store operand across all lanes; the byte enables pick the live lane.
  function automatic logic [31:0] steer_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   steer_wdata = {4{d[7:0]}};
      2'b01:   steer_wdata = {2{d[15:0]}};
      default: steer_wdata = d;
    endcase
  endfunction

  // Pick the addressed byte/half out of the returned word and extend it.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] rdata);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = rdata >> {a, 3'b000};
    b       = shifted[7:0];
    h       = a[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b100:  load_extend = {24'd0, b};
      3'b101:  load_extend = {16'd0, h};
      default: load_extend = rdata;
    endcase
  endfunction

  assign addr_lo      = alu_result_i[1:0];
  assign access       = mem_valid_i & (mem_read_i | mem_write_i);
  assign misaligned_c = access & (((funct3_i[1:0] == 2'b01) & addr_lo[0]) |
                                  ((funct3_i[1:0] == 2'b10) & (addr_lo != 2'b00)) |
                                   (funct3_i[1:0] == 2'b11));
  assign go           = access & ~misaligned_c;
  assign is_store     = mem_write_i;
  assign load_ext     = load_extend(funct3_i, addr_lo, dm_rdata_i);
  assign err_c        = misaligned_c | timeout_c;

  // Next-state, request, stall and timeout decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    req_c     = 1'b0;
    stall_c   = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          req_c = 1'b1;
          if (dm_gnt_i) begin
            if (!is_store) begin
              state_d = RESP;
              stall_c = 1'b1;
            end
          end else begin
            state_d = REQ;
            stall_c = 1'b1;
          end
        end
      end
      REQ: begin
        req_c = 1'b1;
        if (dm_gnt_i) begin
          if (is_store) begin
            state_d = IDLE;
          end else begin
            state_d = RESP;
            stall_c = 1'b1;
          end
        end else begin
          stall_c = 1'b1;
        end
      end
      RESP: begin
        if (dm_rvalid_i) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(RESP_TIMEOUT - 1)) begin
          state_d   = IDLE;
          timeout_c = 1'b1;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory port and stall are forced quiet while reset is held.
  assign dm_req_o   = rst & req_c;
  assign dm_we_o    = (rst & req_c & is_store) ? steer_we(funct3_i, addr_lo) : 4'b0000;
  assign dm_addr_o  = {alu_result_i[31:2], 2'b00};
  assign dm_wdata_o = steer_wdata(funct3_i, store_data_i);
  assign stall_o    = rst & stall_c;
  assign fwd_data_o = alu_result_i;

  // FSM state and response-wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---- MEM / WB boundary ----
  // Bubble while stalled; otherwise capture the completing instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_p1     <= 1'b0;
      wb_reg_write_p1 <= 1'b0;
      wb_rd_p1        <= 5'd0;
      wb_data_p1      <= '0;
      misaligned_p1   <= 1'b0;
      bus_err_p1      <= 1'b0;
    end else begin
      misaligned_p1 <= misaligned_c & (state_q == IDLE);
      bus_err_p1    <= timeout_c;
      if (!stall_c) begin
        wb_valid_p1     <= mem_valid_i & ~err_c;
        wb_reg_write_p1 <= reg_write_i & mem_valid_i & ~err_c;
        wb_rd_p1        <= rd_addr_i;
        wb_data_p1      <= mem_to_reg_i ? load_ext : alu_result_i;
      end else begin
        wb_valid_p1     <= 1'b0;
        wb_reg_write_p1 <= 1'b0;
      end
    end
  end

  assign wb_valid_o     = wb_valid_p1;
  assign wb_reg_write_o = wb_reg_write_p1;
  assign wb_rd_o        = wb_rd_p1;
  assign wb_data_o      = wb_data_p1;
  assign misaligned_o   = misaligned_p1;
  assign bus_err_o      = bus_err_p1;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed test of mem_stage with a write-back scoreboard.
// The stimulus process checks the memory port and stall each cycle and
// pushes the expected MEM/WB result; a monitor pops and compares whenever
// the stage presents a write-back, a misalignment or a bus-error pulse.
module tb_mem_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_read, mem_write, mem_to_reg, reg_write;
  logic [4:0]  rd_addr;
  logic [2:0]  funct3;
  logic [31:0] alu_result, store_data;
  logic        dm_req;
  logic [3:0]  dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        stall;
  logic [31:0] fwd_data;
  logic        misaligned, bus_err;
  logic        wb_valid, wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  typedef struct {
    logic        valid;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total  = 0;
  int   passed = 0;

  mem_stage #(.DATA_WIDTH(32), .RESP_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(mem_valid), .mem_read_i(mem_read), .mem_write_i(mem_write),
    .mem_to_reg_i(mem_to_reg), .reg_write_i(reg_write), .rd_addr_i(rd_addr),
    .funct3_i(funct3), .alu_result_i(alu_result), .store_data_i(store_data),
    .dm_req_o(dm_req), .dm_we_o(dm_we), .dm_addr_o(dm_addr), .dm_wdata_o(dm_wdata),
    .dm_gnt_i(dm_gnt), .dm_rvalid_i(dm_rvalid), .dm_rdata_i(dm_rdata),
    .stall_o(stall), .fwd_data_o(fwd_data),
    .misaligned_o(misaligned), .bus_err_o(bus_err),
    .wb_valid_o(wb_valid), .wb_reg_write_o(wb_reg_write),
    .wb_rd_o(wb_rd), .wb_data_o(wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push(input logic v, input logic rw, input logic [4:0] rd,
                      input logic [31:0] d, input logic mis, input logic berr);
    exp_t e;
    e.valid = v; e.reg_write = rw; e.rd = rd; e.data = d; e.mis = mis; e.berr = berr;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    mem_to_reg = 1'b0; reg_write = 1'b0;
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
  endtask

  task automatic set_instr(input logic rd_en, input logic wr_en, input logic m2r,
                           input logic rw, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [31:0] alu, input logic [31:0] sd);
    mem_valid = 1'b1; mem_read = rd_en; mem_write = wr_en;
    mem_to_reg = m2r; reg_write = rw; rd_addr = rd;
    funct3 = f3; alu_result = alu; store_data = sd;
  endtask

  task automatic do_alu(input logic [4:0] rd, input logic [31:0] alu);
    set_instr(1'b0, 1'b0, 1'b0, 1'b1, rd, 3'b010, alu, 32'h0);
    @(negedge clk);
    chk("alu_stall", {31'd0, stall}, 32'd0);
    chk("alu_req", {31'd0, dm_req}, 32'd0);
    chk("alu_fwd", fwd_data, alu);
    push(1'b1, 1'b1, rd, alu, 1'b0, 1'b0);
    step();
    clr();
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] d,
                          input int gw, input logic [3:0] exp_we, input logic [31:0] exp_wd);
    set_instr(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, f3, addr, d);
    for (int i = 0; i < gw; i++) begin
      @(negedge clk);
      chk("st_wait_req", {31'd0, dm_req}, 32'd1);
      chk("st_wait_we", {28'd0, dm_we}, {28'd0, exp_we});
      chk("st_wait_addr", dm_addr, addr & 32'hFFFF_FFFC);
      chk("st_wait_stall", {31'd0, stall}, 32'd1);
      step();
    end
    dm_gnt = 1'b1;
    @(negedge clk);
    chk("st_req", {31'd0, dm_req}, 32'd1);
    chk("st_we", {28'd0, dm_we}, {28'd0, exp_we});
    chk("st_wdata", dm_wdata, exp_wd);
    chk("st_addr", dm_addr, addr & 32'hFFFF_FFFC);
    chk("st_stall", {31'd0, stall}, 32'd0);
    push(1'b1, 1'b0, 5'd0, addr, 1'b0, 1'b0);
    step();
    clr();
  endtask

  // gw: cycles before gnt; rw: RESP cycles before rvalid; irv: rvalid alongside gnt in IDLE.
  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                         input int gw, input int rw, input logic irv,
                         input logic [31:0] rdata, input logic [31:0] exp);
    set_instr(1'b1, 1'b0, 1'b1, 1'b1, rd, f3, addr, 32'h0);
    for (int i = 0; i < gw; i++) begin
      @(negedge clk);
      chk("ld_wait_req", {31'd0, dm_req}, 32'd1);
      chk("ld_wait_stall", {31'd0, stall}, 32'd1);
      step();
    end
    dm_gnt = 1'b1;
    if (irv) begin
      dm_rvalid = 1'b1;
      dm_rdata  = 32'h1111_1111;
    end
    @(negedge clk);
    chk("ld_req", {31'd0, dm_req}, 32'd1);
    chk("ld_we", {28'd0, dm_we}, 32'd0);
    chk("ld_addr", dm_addr, addr & 32'hFFFF_FFFC);
    chk("ld_gnt_stall", {31'd0, stall}, 32'd1);
    step();
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
    for (int i = 0; i < rw; i++) begin
      @(negedge clk);
      chk("ld_resp_req", {31'd0, dm_req}, 32'd0);
      chk("ld_resp_stall", {31'd0, stall}, 32'd1);
      step();
    end
    dm_rvalid = 1'b1;
    dm_rdata  = rdata;
    @(negedge clk);
    chk("ld_rv_stall", {31'd0, stall}, 32'd0);
    push(1'b1, 1'b1, rd, exp, 1'b0, 1'b0);
    step();
    clr();
  endtask

  task automatic do_mis(input logic [31:0] addr, input logic [2:0] f3, input logic wr);
    set_instr(~wr, wr, ~wr, ~wr, 5'd9, f3, addr, 32'h1234_5678);
    @(negedge clk);
    chk("mis_req", {31'd0, dm_req}, 32'd0);
    chk("mis_stall", {31'd0, stall}, 32'd0);
    push(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    step();
    clr();
  endtask

  // Scoreboard monitor: any write-back or pulse must match the next expectation.
  always @(negedge clk) begin
    if (rst && (wb_valid || misaligned || bus_err)) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL wb_unexpected: got valid=%0b mis=%0b berr=%0b rd=%0d data=0x%08h, expected no output",
                 wb_valid, misaligned, bus_err, wb_rd, wb_data);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_valid", {31'd0, wb_valid}, {31'd0, mon_e.valid});
        chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, mon_e.reg_write});
        chk("misaligned", {31'd0, misaligned}, {31'd0, mon_e.mis});
        chk("bus_err", {31'd0, bus_err}, {31'd0, mon_e.berr});
        if (mon_e.valid) begin
          chk("wb_rd", {27'd0, wb_rd}, {27'd0, mon_e.rd});
          chk("wb_data", wb_data, mon_e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before 100000 ns");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    rd_addr = 5'd0; funct3 = 3'b000; alu_result = 32'h0; store_data = 32'h0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_req", {31'd0, dm_req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b1;
    step();

    do_alu(5'd5, 32'h0000_1234);

    do_store(32'h0000_0103, 3'b000, 32'hAABB_CCDD, 2, 4'b1000, 32'hDDDD_DDDD);
    do_store(32'h0000_0101, 3'b000, 32'h0000_00EE, 0, 4'b0010, 32'hEEEE_EEEE);
    do_store(32'h0000_0102, 3'b001, 32'h1234_5678, 1, 4'b1100, 32'h5678_5678);
    do_store(32'h0000_0010, 3'b010, 32'hCAFE_BABE, 0, 4'b1111, 32'hCAFE_BABE);

    do_load(32'h0000_0202, 3'b000, 5'd7,  0, 2, 1'b0, 32'h0080_FF00, 32'hFFFF_FF80);
    do_load(32'h0000_0202, 3'b100, 5'd8,  0, 1, 1'b1, 32'h0080_FF00, 32'h0000_0080);
    do_load(32'h0000_0302, 3'b001, 5'd9,  1, 0, 1'b0, 32'h8001_1234, 32'hFFFF_8001);
    do_load(32'h0000_0300, 3'b101, 5'd10, 0, 0, 1'b0, 32'h1234_F00D, 32'h0000_F00D);
    do_load(32'h0000_0304, 3'b010, 5'd11, 2, 1, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_load(32'h0000_0201, 3'b000, 5'd13, 0, 0, 1'b0, 32'h0000_7F00, 32'h0000_007F);

    do_mis(32'h0000_0206, 3'b010, 1'b0);
    do_mis(32'h0000_0101, 3'b001, 1'b1);
    do_mis(32'h0000_0303, 3'b101, 1'b0);
    do_mis(32'h0000_0000, 3'b011, 1'b0);
    do_alu(5'd6, 32'h0000_5555);

    // Response timeout: granted load, rvalid never returns.
    set_instr(1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 3'b010, 32'h0000_0400, 32'h0);
    dm_gnt = 1'b1;
    @(negedge clk);
    chk("to_gnt_stall", {31'd0, stall}, 32'd1);
    step();
    dm_gnt = 1'b0;
    dm_rdata = 32'h1234_5678;
    for (int i = 0; i < TO - 1; i++) begin
      @(negedge clk);
      chk("to_wait_stall", {31'd0, stall}, 32'd1);
      step();
    end
    @(negedge clk);
    chk("to_final_stall", {31'd0, stall}, 32'd0);
    chk("to_final_req", {31'd0, dm_req}, 32'd0);
    push(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    step();
    clr();
    do_load(32'h0000_0308, 3'b010, 5'd14, 0, 0, 1'b0, 32'h0BAD_F00D, 32'h0BAD_F00D);

    // Reset while a load waits in RESP.
    set_instr(1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 3'b010, 32'h0000_0500, 32'h0);
    dm_gnt = 1'b1;
    step();
    dm_gnt = 1'b0;
    @(negedge clk);
    chk("rr_resp_stall", {31'd0, stall}, 32'd1);
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("rr_req", {31'd0, dm_req}, 32'd0);
    chk("rr_stall", {31'd0, stall}, 32'd0);
    chk("rr_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rr_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
    chk("rr_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rr_wb_data", wb_data, 32'd0);
    step();
    rst = 1'b1;
    clr();
    step();
    dm_rvalid = 1'b1;
    dm_rdata  = 32'hCAFE_F00D;
    @(negedge clk);
    chk("late_rv_stall", {31'd0, stall}, 32'd0);
    step();
    clr();
    @(negedge clk);
    chk("late_rv_wb_valid", {31'd0, wb_valid}, 32'd0);
    step();
    do_alu(5'd31, 32'hFFFF_0000);

    repeat (3) step();
    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
